// File: rtl/alu_packet_parser.sv
// Byte-stream packet parser for the ALU: header decode, then 32-bit little-endian operand words.
// Optional macro PARSER_ERR_CNT_EN adds a saturating malformed-packet counter on err_cnt_o.
module alu_packet_parser #(
  parameter int DATA_WIDTH_P = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [7:0]              m_opcode_o,
  output logic [31:0]             m_word_o,
  output logic                    m_valid_o,
  output logic                    m_last_o,
  input  logic                    m_ready_i,
  output logic                    err_o
`ifdef PARSER_ERR_CNT_EN
  ,output logic [7:0]             err_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_DISCARD
  } state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  state_t      state;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;     // bytes still to come in the payload/discard phase
  logic [1:0]  idx_q;     // byte lane of the next payload byte
  logic [23:0] acc_q;     // lower three bytes of the word being assembled

  logic [7:0]  in_byte;
  logic        accept;
  logic [15:0] full_len;
  logic        opcode_ok;
  logic [31:0] word_next;

  assign in_byte   = s_axis_tdata[7:0];
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign full_len  = {in_byte, len_lo_q};
  assign opcode_ok = (opcode_q == OP_ECHO) || (opcode_q == OP_ADD) ||
                     (opcode_q == OP_MUL)  || (opcode_q == OP_DIV);

  // Payload backpressure must follow m_ready_i in the same cycle, so tready is combinational.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s_axis_tready = 1'b1;
    if (rst)
      s_axis_tready = 1'b0;
    else if (state == S_PAYLOAD)
      s_axis_tready = !m_valid_o || m_ready_i;
  end

  // Lanes above the incoming byte are zero, which gives zero-fill on a short final word.
  always_comb begin
    word_next = 32'h0;
    case (idx_q)
      2'd0:    word_next = {24'h0, in_byte};
      2'd1:    word_next = {16'h0, in_byte, acc_q[7:0]};
      2'd2:    word_next = {8'h0, in_byte, acc_q[15:0]};
      default: word_next = {in_byte, acc_q};
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; the later assignment in this
    // block wins, which lets a freshly loaded word override the accept-clear below.
    if (rst) begin
      state      <= S_OPCODE;
      opcode_q   <= 8'h0;
      len_lo_q   <= 8'h0;
      rem_q      <= 16'h0;
      idx_q      <= 2'd0;
      acc_q      <= 24'h0;
      m_opcode_o <= 8'h0;
      m_word_o   <= 32'h0;
      m_valid_o  <= 1'b0;
      m_last_o   <= 1'b0;
      err_o      <= 1'b0;
`ifdef PARSER_ERR_CNT_EN
      err_cnt_o  <= 8'h0;
`endif
    end else begin
      err_o <= 1'b0;
`ifdef PARSER_ERR_CNT_EN
      if (err_o && (err_cnt_o != 8'hFF))
        err_cnt_o <= err_cnt_o + 8'd1;
`endif
      if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end

      if (accept) begin
        case (state)
          S_OPCODE: begin
            opcode_q <= in_byte;
            state    <= S_RSVD;
          end
          S_RSVD:   state <= S_LEN_LO;
          S_LEN_LO: begin
            len_lo_q <= in_byte;
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            idx_q <= 2'd0;
            if (full_len <= 16'd4) begin
              err_o <= 1'b1;
              state <= S_OPCODE;
            end else if (!opcode_ok || (full_len < 16'd8)) begin
              err_o <= 1'b1;
              rem_q <= full_len - 16'd4;
              state <= S_DISCARD;
            end else begin
              rem_q <= full_len - 16'd4;
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            rem_q <= rem_q - 16'd1;
            if ((idx_q == 2'd3) || (rem_q == 16'd1)) begin
              m_word_o   <= word_next;
              m_valid_o  <= 1'b1;
              m_last_o   <= (rem_q == 16'd1);
              m_opcode_o <= opcode_q;
              idx_q      <= 2'd0;
            end else begin
              case (idx_q)
                2'd0:    acc_q[7:0]   <= in_byte;
                2'd1:    acc_q[15:8]  <= in_byte;
                default: acc_q[23:16] <= in_byte;
              endcase
              idx_q <= idx_q + 2'd1;
            end
            if (rem_q == 16'd1)
              state <= S_OPCODE;
          end
          S_DISCARD: begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1)
              state <= S_OPCODE;
          end
          default: state <= S_OPCODE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser: table of packets plus stall, opcode-hold and reset sequences.
module tb_alu_packet_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_opcode_o;
  logic [31:0] m_word_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i;
  logic        err_o;
`ifdef PARSER_ERR_CNT_EN
  logic [7:0]  err_cnt_o;
`endif

  alu_packet_parser #(.DATA_WIDTH_P(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_opcode_o    (m_opcode_o),
    .m_word_o      (m_word_o),
    .m_valid_o     (m_valid_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i),
    .err_o         (err_o)
`ifdef PARSER_ERR_CNT_EN
    ,.err_cnt_o    (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: records every accepted word and every err_o pulse.
  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [7:0]  op;
  } beat_t;

  beat_t got[$];
  int    err_seen;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid_o && m_ready_i)
        got.push_back('{m_word_o, m_last_o, m_opcode_o});
      if (err_o)
        err_seen++;
    end
  end

  // Drive one byte and hold it until accepted; inputs change #1 after the rising edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited        = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: byte 0x%0h not accepted after %0d cycles", b, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Bytes are listed first-byte-leftmost in the low n bytes of s.
  task automatic send_packet(input logic [127:0] s, input int n);
    for (int i = 0; i < n; i++)
      send_byte(s[(n-1-i)*8 +: 8]);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [127:0] s;
    int           n;
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [7:0]   op;
    int           nerr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] exp_w;
    int          bad;

    vecs[0] = '{128'hA0000C00_01000000_02000000, 12, 2, 32'h00000001, 32'h00000002, 8'hA0, 0};
    vecs[1] = '{128'hEC000900_11223344_55,        9, 2, 32'h44332211, 32'h00000055, 8'hEC, 0};
    vecs[2] = '{128'h7F000600_AABB,               6, 0, 32'h0,        32'h0,        8'h00, 1};
    vecs[3] = '{128'hA1000800_03000000,           8, 1, 32'h00000003, 32'h0,        8'hA1, 0};
    vecs[4] = '{128'hA0000400,                    4, 0, 32'h0,        32'h0,        8'h00, 1};
    vecs[5] = '{128'hA2000700_010203,             7, 0, 32'h0,        32'h0,        8'h00, 1};
    vecs[6] = '{128'hA2000B00_01020304_050607,   11, 2, 32'h04030201, 32'h00070605, 8'hA2, 0};
    vecs[7] = '{128'h7F000400,                    4, 0, 32'h0,        32'h0,        8'h00, 1};
    vecs[8] = '{128'hA0000800_FFFFFFFF,           8, 1, 32'hFFFFFFFF, 32'h0,        8'hA0, 0};

    rst           = 1'b1;
    s_axis_tdata  = 8'h0;
    s_axis_tvalid = 1'b0;
    m_ready_i     = 1'b1;
    err_seen      = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tready",  s_axis_tready, 0);
    check("rst_valid",   m_valid_o,     0);
    check("rst_last",    m_last_o,      0);
    check("rst_err",     err_o,         0);
    check("rst_word",    m_word_o,      0);
    check("rst_opcode",  m_opcode_o,    0);
`ifdef PARSER_ERR_CNT_EN
    check("rst_err_cnt", err_cnt_o,     0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven packets with a free-running consumer
    for (int i = 0; i < 9; i++) begin
      got.delete();
      err_seen = 0;
      send_packet(vecs[i].s, vecs[i].n);
      drain();
      check($sformatf("v%0d_nwords", i), got.size(), vecs[i].nw);
      check($sformatf("v%0d_nerr", i), err_seen, vecs[i].nerr);
      for (int k = 0; k < vecs[i].nw && k < got.size(); k++) begin
        exp_w = (k == 0) ? vecs[i].w0 : vecs[i].w1;
        check($sformatf("v%0d_word%0d", i, k), got[k].word, exp_w);
        check($sformatf("v%0d_last%0d", i, k), got[k].last, (k == vecs[i].nw - 1));
        check($sformatf("v%0d_op%0d", i, k), got[k].op, vecs[i].op);
      end
    end

    // 8-word add packet with the consumer stalled for 20 cycles after the first word
    got.delete();
    err_seen  = 0;
    m_ready_i = 1'b0;
    send_packet(128'hA0002400, 4);
    for (int i = 1; i <= 4; i++)
      send_byte(i[7:0]);
    @(negedge clk);
    check("stall_valid", m_valid_o, 1);
    check("stall_word",  m_word_o, 32'h04030201);
    s_axis_tdata  = 8'd5;
    s_axis_tvalid = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || m_valid_o !== 1'b1 || m_word_o !== 32'h04030201 ||
          m_last_o !== 1'b0 || m_opcode_o !== 8'hA0)
        bad++;
    end
    check("stall_hold", bad, 0);
    @(posedge clk);
    #1;
    m_ready_i = 1'b1;
    for (int i = 5; i <= 32; i++)
      send_byte(i[7:0]);
    drain();
    check("stall_nwords", got.size(), 8);
    check("stall_nerr", err_seen, 0);
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      exp_w = 32'h0;
      for (int j = 0; j < 4; j++)
        exp_w[j*8 +: 8] = 8'(4*k + j + 1);
      check($sformatf("stall_word%0d", k), got[k].word, exp_w);
      check($sformatf("stall_last%0d", k), got[k].last, (k == 7));
    end

    // Header of the next packet accepted while the previous word is still held
    got.delete();
    m_ready_i = 1'b0;
    send_packet(128'hA0000800_01000000, 8);
    send_packet(128'hEC000800, 4);
    @(negedge clk);
    check("hold_valid",  m_valid_o, 1);
    check("hold_opcode", m_opcode_o, 8'hA0);
    @(posedge clk);
    #1;
    m_ready_i = 1'b1;
    send_packet(128'h09000000, 4);
    drain();
    check("hold_nwords", got.size(), 2);
    if (got.size() == 2) begin
      check("hold_word0", got[0].word, 32'h1);
      check("hold_op0",   got[0].op,   8'hA0);
      check("hold_word1", got[1].word, 32'h9);
      check("hold_op1",   got[1].op,   8'hEC);
      check("hold_last1", got[1].last, 1);
    end

    // Reset in the middle of a 12-byte packet
    got.delete();
    err_seen = 0;
    send_packet(128'hA0000C00_1122, 6);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", m_valid_o, 0);
    @(posedge clk);
    #1;
    send_packet(128'hA2000800_08000000, 8);
    drain();
    check("midrst_nwords", got.size(), 1);
    check("midrst_nerr", err_seen, 0);
    if (got.size() == 1) begin
      check("midrst_word", got[0].word, 32'h8);
      check("midrst_op",   got[0].op,   8'hA2);
      check("midrst_last", got[0].last, 1);
    end

`ifdef PARSER_ERR_CNT_EN
    // Error counter saturation
    err_seen = 0;
    for (int i = 0; i < 300; i++)
      send_packet(128'hA0000300, 4);
    drain();
    check("errcnt_pulses", err_seen, 300);
    check("errcnt_sat",    err_cnt_o, 8'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
